// File: rtl/subword_store_rmw_sequencer_pkg.sv
// Shared types and constants for the sub-word store read-modify-write sequencer.
package subword_store_rmw_sequencer_pkg;

  // Internal store operation codes, as presented on req_op.
  typedef enum logic [2:0] {
    OP_SW  = 3'd0,
    OP_SB  = 3'd1,
    OP_SH  = 3'd2,
    OP_SWL = 3'd3,
    OP_SWR = 3'd4
  } op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RDW   = 3'd2,
    MERGE = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  // MIPS primary opcodes of the store family.
  localparam logic [5:0] OPC_SB  = 6'b101000;
  localparam logic [5:0] OPC_SH  = 6'b101001;
  localparam logic [5:0] OPC_SWL = 6'b101010;
  localparam logic [5:0] OPC_SW  = 6'b101011;
  localparam logic [5:0] OPC_SWR = 6'b101110;

  // Decoder helper: maps a primary opcode to {legal, req_op}.
  function automatic logic [3:0] decode_store_opcode(input logic [5:0] opc);
    logic [3:0] r;
    r = 4'b0111;
    case (opc)
      OPC_SB:  r = {1'b1, OP_SB};
      OPC_SH:  r = {1'b1, OP_SH};
      OPC_SWL: r = {1'b1, OP_SWL};
      OPC_SW:  r = {1'b1, OP_SW};
      OPC_SWR: r = {1'b1, OP_SWR};
      default: r = 4'b0111;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/subword_store_rmw_sequencer_merge.sv
// Combinational lane merge: builds the lane mask for a store and merges the
// shifted source data into the old memory word.
module store_lane_merge
  import subword_store_rmw_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b0,
  localparam int LANES     = DATA_W / 8,
  localparam int OFF_W     = $clog2(LANES)
) (
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  offset,
  input  logic [2:0]        op,
  output logic [LANES-1:0]  mask,
  output logic [DATA_W-1:0] merged
);

  // Lane mask and data placement in little-endian lane numbering.
  logic [LANES-1:0]  lmask;
  logic [DATA_W-1:0] shifted;

  // SWL fills lanes 0..offset from the data MSBs; everything else places the
  // data LSBs at lane 'offset' and upward.
  always_comb begin
    lmask = '0;
    if (op == OP_SWL) shifted = data >> (8 * (LANES - 1 - int'(offset)));
    else              shifted = data << (8 * int'(offset));
    for (int i = 0; i < LANES; i++) begin
      case (op)
        OP_SB:   lmask[i] = (i == int'(offset));
        OP_SH:   lmask[i] = (i == int'(offset)) || (i == int'(offset) + 1);
        OP_SWL:  lmask[i] = (i <= int'(offset));
        OP_SWR:  lmask[i] = (i >= int'(offset));
        default: lmask[i] = 1'b1;
      endcase
    end
  end

  // Big-endian mode mirrors lane numbering onto physical byte positions.
  for (genvar p = 0; p < LANES; p++) begin : g_lane
    localparam int L = BIG_ENDIAN ? (LANES - 1 - p) : p;
    assign mask[p]         = lmask[L];
    assign merged[8*p +: 8] = lmask[L] ? shifted[8*L +: 8] : old_word[8*p +: 8];
  end

endmodule

// File: rtl/subword_store_rmw_sequencer.sv
// Sub-word store sequencer for a word-only data memory: read the containing
// word, merge the selected lanes, write it back. Stalls the front end while
// a sequence is in flight.
module subword_store_rmw_sequencer
  import subword_store_rmw_sequencer_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter bit BIG_ENDIAN   = 1'b0,
  parameter bit EN_UNALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  input  logic              mem_waitrequest,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_RD    = RD;
  localparam logic [2:0] S_RDW   = RDW;
  localparam logic [2:0] S_MERGE = MERGE;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_DONE  = DONE;
  localparam logic [2:0] S_ERR   = ERR;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] word_q;
  logic [LANES-1:0]  mask_q;
  logic [LANES-1:0]  mask_c;
  logic [DATA_W-1:0] merged_c;
  logic              accept;
  logic              bad_req;
  logic [OFF_W-1:0]  req_off;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready & clk_enable;

  // Alignment and opcode legality of the incoming request.
  always_comb begin
    bad_req = 1'b0;
    case (req_op)
      OP_SW:          bad_req = (req_off != '0);
      OP_SB:          bad_req = 1'b0;
      OP_SH:          bad_req = req_addr[0];
      OP_SWL, OP_SWR: bad_req = !EN_UNALIGNED;
      default:        bad_req = 1'b1;
    endcase
  end

  // Next-state logic; waitrequest holds RD and WRITE in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = bad_req ? S_ERR : ((req_op == OP_SW) ? S_WRITE : S_RD);
      S_RD:    if (!mem_waitrequest) state_d = S_RDW;
      S_RDW:   state_d = S_MERGE;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: if (!mem_waitrequest) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  store_lane_merge #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_merge (
    .old_word (word_q),
    .data     (data_q),
    .offset   (addr_q[OFF_W-1:0]),
    .op       (op_q),
    .mask     (mask_c),
    .merged   (merged_c)
  );

  // State and datapath registers; clk_enable low freezes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      data_q  <= '0;
      word_q  <= '0;
      mask_q  <= '0;
    end else if (clk_enable) begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= req_addr;
        op_q   <= req_op;
        data_q <= req_data;
        if (req_op == OP_SW) begin
          word_q <= req_data;
          mask_q <= '1;
        end
      end
      if (state_q == S_RDW) word_q <= mem_readdata;
      if (state_q == S_MERGE) begin
        word_q <= merged_c;
        mask_q <= mask_c;
      end
    end
  end

  // A merged write-back always covers at least one lane.
  assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_WRITE && op_q != OP_SW) |-> (mask_q != '0));

  // Outputs decode straight from registered state, so they hold under
  // waitrequest and clk_enable and clear asynchronously on reset.
  assign mem_address   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_read      = (state_q == S_RD);
  assign mem_write     = (state_q == S_WRITE);
  assign mem_writedata = mem_write ? word_q : '0;
  assign stall         = (state_q == S_RD) || (state_q == S_RDW) ||
                         (state_q == S_MERGE) || (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);

endmodule

// File: tb/tb_subword_store_rmw_sequencer.sv
// Directed bench for the sub-word store sequencer with a small word memory model.
module tb_subword_store_rmw_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        stall;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  subword_store_rmw_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .stall           (stall),
    .done            (done),
    .err             (err)
  );

  // Memory model: 16 words, registered read data, programmable wait counts.
  logic [31:0] mem [16];
  logic [31:0] rd_q = '0;
  int          rd_wait_left = 0;
  int          wr_wait_left = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  logic        pre_req = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          pre_rdw = 0;
  int          pre_wrw = 0;

  assign mem_readdata    = rd_q;
  assign mem_waitrequest = (mem_read && rd_wait_left > 0) || (mem_write && wr_wait_left > 0);

  always @(posedge clk) begin
    if (pre_req) begin
      mem[pre_idx] <= pre_val;
      rd_wait_left <= pre_rdw;
      wr_wait_left <= pre_wrw;
    end else if (reset && clk_enable) begin
      if (mem_read) begin
        if (mem_waitrequest) rd_wait_left <= rd_wait_left - 1;
        else begin
          rd_q <= mem[mem_address[5:2]];
          n_rd <= n_rd + 1;
        end
      end
      if (mem_write) begin
        if (mem_waitrequest) wr_wait_left <= wr_wait_left - 1;
        else begin
          mem[mem_address[5:2]] <= mem_writedata;
          n_wr <= n_wr + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one request, follow it to done/err, then check result and bus behaviour.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, data, init, word,
                         input bit is_err, input int lat, st, rdw, wrw, frz_at, frz_len,
                         input string tag);
    int n, got_lat, nst, bad_a, bad_d, both, frz_left, rd0, wr0, exp_rd;
    bit got_err;
    logic [67:0] snap, cur;
    n = 0; got_lat = -1; nst = 0; bad_a = 0; bad_d = 0; both = 0; frz_left = 0;
    got_err = 1'b0; snap = '0;
    @(negedge clk);
    pre_req = 1'b1; pre_idx = addr[5:2]; pre_val = init; pre_rdw = rdw; pre_wrw = wrw;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(posedge clk);
    #1;
    pre_req = 1'b0; req_valid = 1'b0;
    rd0 = n_rd; wr0 = n_wr;
    while (got_lat < 0 && n < 40) begin
      @(negedge clk);
      n++;
      cur = {mem_read, mem_write, stall, done, mem_address, mem_writedata};
      if (frz_left > 0) begin
        chk({tag, ":frozen"}, cur, snap);
        frz_left--;
        if (frz_left == 0) clk_enable = 1'b1;
      end else if (n == frz_at) begin
        snap = cur;
        clk_enable = 1'b0;
        frz_left = frz_len;
      end
      if (stall) nst++;
      if (mem_read && mem_write) both++;
      if ((mem_read || mem_write) && mem_address != {addr[31:2], 2'b00}) bad_a++;
      if (mem_write && mem_writedata != word) bad_d++;
      if (done || err) begin
        got_lat = n;
        got_err = err;
      end
    end
    clk_enable = 1'b1;
    exp_rd = (is_err || op == 3'd0) ? 0 : 1;
    chk({tag, ":kind"}, got_err, is_err);
    chk({tag, ":latency"}, got_lat, lat);
    chk({tag, ":stall_cycles"}, nst, st);
    chk({tag, ":word"}, mem[addr[5:2]], word);
    chk({tag, ":writes"}, n_wr - wr0, is_err ? 0 : 1);
    chk({tag, ":reads"}, n_rd - rd0, exp_rd);
    chk({tag, ":bus_hazards"}, {both[7:0], bad_a[7:0], bad_d[7:0]}, 24'd0);
    @(negedge clk);
    chk({tag, ":ready_after"}, req_ready, 1'b1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] init;
    logic [31:0] word;
    bit          is_err;
    int          lat;
    int          st;
  } vec_t;

  vec_t v[14];
  int   wr0;

  initial begin
    v[0]  = '{3'd1, 32'h101, 32'h000000AB, 32'h11223344, 32'h1122AB44, 1'b0, 5, 4};
    v[1]  = '{3'd2, 32'h102, 32'h0000BEEF, 32'h11223344, 32'hBEEF3344, 1'b0, 5, 4};
    v[2]  = '{3'd2, 32'h103, 32'h0000BEEF, 32'h11223344, 32'h11223344, 1'b1, 1, 0};
    v[3]  = '{3'd3, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'h1122AABB, 1'b0, 5, 4};
    v[4]  = '{3'd4, 32'h101, 32'hAABBCCDD, 32'h11223344, 32'hBBCCDD44, 1'b0, 5, 4};
    v[5]  = '{3'd0, 32'h100, 32'hCAFEBABE, 32'h11223344, 32'hCAFEBABE, 1'b0, 2, 1};
    v[6]  = '{3'd0, 32'h102, 32'hCAFEBABE, 32'h11223344, 32'h11223344, 1'b1, 1, 0};
    v[7]  = '{3'd5, 32'h100, 32'hCAFEBABE, 32'h11223344, 32'h11223344, 1'b1, 1, 0};
    v[8]  = '{3'd1, 32'h103, 32'h00001234, 32'h11223344, 32'h34223344, 1'b0, 5, 4};
    v[9]  = '{3'd3, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h112233AA, 1'b0, 5, 4};
    v[10] = '{3'd4, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'hDD223344, 1'b0, 5, 4};
    v[11] = '{3'd3, 32'h103, 32'hAABBCCDD, 32'h11223344, 32'hAABBCCDD, 1'b0, 5, 4};
    v[12] = '{3'd2, 32'h100, 32'h0000BEEF, 32'h11223344, 32'h1122BEEF, 1'b0, 5, 4};
    v[13] = '{3'd7, 32'h100, 32'h0000BEEF, 32'h11223344, 32'h11223344, 1'b1, 1, 0};

    clk_enable = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0; req_data = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    chk("reset:ctl", {req_ready, mem_read, mem_write, stall, done, err}, 6'b100000);
    chk("reset:addr", mem_address, 32'h0);
    chk("reset:wdata", mem_writedata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++)
      run_req(v[i].op, v[i].addr, v[i].data, v[i].init, v[i].word, v[i].is_err,
              v[i].lat, v[i].st, 0, 0, -1, 0, $sformatf("vec%0d", i));

    // Waitrequest: 3 cycles on the read, 2 on the write.
    run_req(3'd1, 32'h101, 32'hAB, 32'h11223344, 32'h1122AB44, 1'b0, 10, 9, 3, 2, -1, 0, "wait");

    // clk_enable low for 3 cycles while in RDW.
    run_req(3'd1, 32'h101, 32'hAB, 32'h11223344, 32'h1122AB44, 1'b0, 8, 7, 0, 0, 2, 3, "freeze");

    // Reset asserted in MERGE: outputs clear at once and no write follows.
    @(negedge clk);
    pre_req = 1'b1; pre_idx = 4'd0; pre_val = 32'h11223344; pre_rdw = 0; pre_wrw = 0;
    req_valid = 1'b1; req_op = 3'd1; req_addr = 32'h101; req_data = 32'hAB;
    @(posedge clk);
    #1;
    pre_req = 1'b0; req_valid = 1'b0;
    wr0 = n_wr;
    repeat (3) @(negedge clk);
    chk("rst_mid:stall_before", {stall, mem_read, mem_write}, 3'b100);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid:ctl", {req_ready, mem_read, mem_write, stall, done, err}, 6'b100000);
    chk("rst_mid:addr", mem_address, 32'h0);
    chk("rst_mid:wdata", mem_writedata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid:writes", n_wr - wr0, 0);
    chk("rst_mid:word", mem[0], 32'h11223344);
    chk("rst_mid:ready", req_ready, 1'b1);

    // Normal operation resumes after the abort.
    run_req(3'd2, 32'h102, 32'hBEEF, 32'h11223344, 32'hBEEF3344, 1'b0, 5, 4, 0, 0, -1, 0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
